// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, fetches words over the imem req/ack bus and fills the IF/ID register,
// with decode stall/flush and execute-stage branch redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         BranchTakenE,
  input  logic [31:0]  BranchTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCD,
  output logic [31:0]  PCPlus8D,
  output logic         ValidD
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pcf_q;
  logic [31:0] hold_q;
  logic [31:0] instrD_q;
  logic [31:0] pcD_q;
  logic [31:0] pcPlus8D_q;
  logic        validD_q;

  logic [31:0] pcfPlus4;
  logic [31:0] pcfPlus8;
  logic        fetchStall;

  assign pcfPlus4 = pcf_q + 32'd4;
  assign pcfPlus8 = pcf_q + 32'd8;

  // A flush empties IF/ID anyway, so the fetch path behaves as if decode were not stalled.
  assign fetchStall = StallD & ~FlushD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pcf_q      <= RESET_PC;
      hold_q     <= '0;
      instrD_q   <= NOP_INSTR;
      pcD_q      <= '0;
      pcPlus8D_q <= '0;
      validD_q   <= 1'b0;
    end else if (BranchTakenE) begin
      state_q  <= S_REQ;
      pcf_q    <= BranchTargetE & ~32'h3;
      hold_q   <= '0;
      instrD_q <= NOP_INSTR;
      validD_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (!fetchStall) begin
              instrD_q   <= imem.imem_rdata;
              pcD_q      <= pcf_q;
              pcPlus8D_q <= pcfPlus8;
              validD_q   <= 1'b1;
              pcf_q      <= pcfPlus4;
            end else begin
              hold_q  <= imem.imem_rdata;
              state_q <= S_HOLD;
            end
          end else if (!fetchStall) begin
            instrD_q <= NOP_INSTR;
            validD_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!fetchStall) begin
            instrD_q   <= hold_q;
            pcD_q      <= pcf_q;
            pcPlus8D_q <= pcfPlus8;
            validD_q   <= 1'b1;
            pcf_q      <= pcfPlus4;
            state_q    <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
      // Flush overrides whatever the fetch path wrote into IF/ID this cycle.
      if (FlushD) begin
        instrD_q <= NOP_INSTR;
        validD_q <= 1'b0;
      end
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pcf_q;

  assign InstrD   = instrD_q;
  assign PCD      = pcD_q;
  assign PCPlus8D = pcPlus8D_q;
  assign ValidD   = validD_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD;
  logic        FlushD;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus8D;
  logic        ValidD;

  fetch_stage_if imemIf();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .BranchTakenE (BranchTakenE),
    .BranchTargetE(BranchTargetE),
    .imem         (imemIf),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus8D     (PCPlus8D),
    .ValidD       (ValidD)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Model: current fetch address, an optional word fetched but not yet delivered, and IF/ID.
  logic [31:0] mPc;
  bit          mHeld;
  logic [31:0] mHeldWord;
  bit          mValid;
  logic [31:0] mInstr;
  logic [31:0] mPcD;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_req", {31'b0, imemIf.imem_req}, {31'b0, !mHeld});
    checkOutput("imem_addr", imemIf.imem_addr, mPc);
    checkOutput("ValidD", {31'b0, ValidD}, {31'b0, mValid});
    checkOutput("InstrD", InstrD, mInstr);
    if (mValid) begin
      checkOutput("PCD", PCD, mPcD);
      checkOutput("PCPlus8D", PCPlus8D, mPcD + 32'd8);
    end
  endtask

  task automatic modelStep(input bit r, input bit b, input logic [31:0] t,
                           input bit f, input bit s, input bit ack);
    bit          haveWord;
    logic [31:0] word;
    if (r) begin
      mPc = 32'h0; mHeld = 0; mValid = 0; mInstr = NOP; mPcD = 32'h0;
    end else if (b) begin
      mPc = {t[31:2], 2'b00}; mHeld = 0; mValid = 0; mInstr = NOP;
    end else begin
      haveWord = mHeld || ack;
      word     = mHeld ? mHeldWord : memWord(mPc);
      if (haveWord && !(s && !f)) begin
        mInstr = word; mPcD = mPc; mValid = 1; mPc = mPc + 32'd4; mHeld = 0;
      end else if (haveWord) begin
        mHeld = 1; mHeldWord = word;
      end else if (!(s && !f)) begin
        mInstr = NOP; mValid = 0;
      end
      if (f) begin
        mInstr = NOP; mValid = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit b, input logic [31:0] t,
                               input bit f, input bit s, input bit a);
    rst           = r;
    BranchTakenE  = b;
    BranchTargetE = t;
    FlushD        = f;
    StallD        = s;
    imemIf.imem_ack   = a && !mHeld;
    imemIf.imem_rdata = imemIf.imem_ack ? memWord(imemIf.imem_addr) : $urandom();
    modelStep(r, b, t, f, s, imemIf.imem_ack);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    int valids;
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; BranchTargetE = '0;
    imemIf.imem_ack = 1'b0; imemIf.imem_rdata = '0;
    mPc = '0; mHeld = 0; mHeldWord = '0; mValid = 0; mInstr = NOP; mPcD = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_valid", {31'b0, ValidD}, 32'h0);
    checkOutput("rst_instr", InstrD, 32'hE1A0_0000);
    checkOutput("rst_pcd", PCD, 32'h0);
    checkOutput("rst_pc8", PCPlus8D, 32'h0);
    checkOutput("rst_addr", imemIf.imem_addr, 32'h0);
    checkOutput("rst_req", {31'b0, imemIf.imem_req}, 32'h1);

    // Back-to-back single-cycle acks
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t1_valid", {31'b0, ValidD}, 32'h1);
      checkOutput("t1_pcd", PCD, 32'(i * 4));
      checkOutput("t1_pc8", PCPlus8D, 32'(i * 4 + 8));
    end

    // Stall on the ack of 0x10, hold for four cycles, then release
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("t3_req", {31'b0, imemIf.imem_req}, 32'h0);
      checkOutput("t3_pcd", PCD, 32'hC);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_instr", InstrD, memWord(32'h10));
    checkOutput("t3_pcd", PCD, 32'h10);
    checkOutput("t3_addr", imemIf.imem_addr, 32'h14);

    // Ack only every third cycle
    valids = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 0, 0, 0, (i % 3) == 2);
      if ((i % 3) != 2) begin
        checkOutput("t2_gap_valid", {31'b0, ValidD}, 32'h0);
        checkOutput("t2_gap_instr", InstrD, 32'hE1A0_0000);
      end else if (ValidD) begin
        valids++;
      end
    end
    checkOutput("t2_count", 32'(valids), 32'd3);
    checkOutput("t2_addr", imemIf.imem_addr, 32'h20);

    // Branch while stalled with an ack in the same cycle
    applyStimulus(0, 1, 32'h0000_0103, 0, 1, 1);
    checkOutput("t4_valid", {31'b0, ValidD}, 32'h0);
    checkOutput("t4_addr", imemIf.imem_addr, 32'h100);
    checkOutput("t4_instr", InstrD, 32'hE1A0_0000);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_pcd", PCD, 32'h100);
    checkOutput("t4_instr2", InstrD, memWord(32'h100));

    // Flush with stall: IF/ID emptied, fetch still advances
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("t5_valid", {31'b0, ValidD}, 32'h0);
    checkOutput("t5_instr", InstrD, 32'hE1A0_0000);
    checkOutput("t5_addr", imemIf.imem_addr, 32'h108);

    // Address wrap, then reset while holding
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t6_pcd", PCD, 32'hFFFF_FFFC);
    checkOutput("t6_pc8", PCPlus8D, 32'h4);
    checkOutput("t6_addr", imemIf.imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t6_hold_req", {31'b0, imemIf.imem_req}, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("t6_rst_addr", imemIf.imem_addr, 32'h0);
    checkOutput("t6_rst_valid", {31'b0, ValidD}, 32'h0);
    checkOutput("t6_rst_req", {31'b0, imemIf.imem_req}, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      applyStimulus($urandom_range(63) == 0,
                    $urandom_range(15) == 0,
                    tgt,
                    $urandom_range(9) == 0,
                    $urandom_range(2) == 0,
                    $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
